// File: rtl/omsp_spm_protect_ctrl.sv
// Sancus protect sequencer: overlap check, layout commit with a fresh ID,
// then stream the derived module key into the newly enabled SPM.
module omsp_spm_protect_ctrl #(
  parameter int KEY_IDX_SIZE = 2,
  parameter int KEY_WORDS    = 4,
  parameter int KDF_TIMEOUT  = 255
) (
  input  logic                    mclk,
  input  logic                    puc_rst,
  input  logic                    start,
  input  logic [15:0]             r12,
  input  logic [15:0]             r13,
  input  logic [15:0]             r14,
  input  logic [15:0]             r15,
  input  logic                    violation_any,
  input  logic                    kdf_valid,
  input  logic [15:0]             kdf_data,
  output logic                    busy,
  output logic                    check_new_spm,
  output logic                    update_spm,
  output logic                    enable_spm,
  output logic [15:0]             next_id,
  output logic [15:0]             spm_key_select,
  output logic                    kdf_start,
  output logic                    kdf_ready,
  output logic                    write_key,
  output logic [15:0]             key_in,
  output logic [KEY_IDX_SIZE-1:0] key_idx,
  output logic                    done,
  output logic                    success
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_ENABLE  = 3'd2,
    S_KDF_REQ = 3'd3,
    S_KEY_WR  = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [KEY_IDX_SIZE-1:0] LAST_WORD = KEY_IDX_SIZE'(KEY_WORDS - 1);
  localparam logic [7:0]              TMO_LAST  = 8'(KDF_TIMEOUT - 1);

  state_t                  state_q, state_d;
  logic                    valid_cfg_q;
  logic [15:0]             key_sel_q;
  logic [15:0]             next_id_q, next_id_d;
  logic [KEY_IDX_SIZE-1:0] cnt_q;
  logic [7:0]              tmo_q;
  logic                    success_q;
  logic                    ok_d;
  logic                    busy_q, chk_q, upd_q, kdfs_q, rdy_q, done_q;

  // ID 0 means "unprotected", so the counter skips it on wrap.
  assign next_id_d = (next_id_q == 16'hFFFF) ? 16'h0001 : next_id_q + 16'h0001;

  // The only successful exit: last key word accepted this cycle.
  assign ok_d = (state_q == S_KEY_WR) && kdf_valid && (cnt_q == LAST_WORD);

  // Next-state decode; strobes below are registered from this.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_CHECK;
      S_CHECK:   state_d = (violation_any || !valid_cfg_q) ? S_DONE : S_ENABLE;
      S_ENABLE:  state_d = S_KDF_REQ;
      S_KDF_REQ: state_d = S_KEY_WR;
      S_KEY_WR: begin
        if (kdf_valid) begin
          if (cnt_q == LAST_WORD) state_d = S_DONE;
        end else if (tmo_q == TMO_LAST) begin
          // this idle cycle brings the wait count to KDF_TIMEOUT
          state_d = S_DONE;
        end
      end
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // FSM state, registered Moore strobes and the operation datapath.
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state_q     <= S_IDLE;
      valid_cfg_q <= 1'b0;
      key_sel_q   <= 16'h0000;
      next_id_q   <= 16'h0001;
      cnt_q       <= '0;
      tmo_q       <= 8'h00;
      success_q   <= 1'b0;
      busy_q      <= 1'b0;
      chk_q       <= 1'b0;
      upd_q       <= 1'b0;
      kdfs_q      <= 1'b0;
      rdy_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != S_IDLE);
      chk_q   <= (state_d == S_CHECK);
      upd_q   <= (state_d == S_ENABLE);
      kdfs_q  <= (state_d == S_KDF_REQ);
      rdy_q   <= (state_d == S_KEY_WR);
      done_q  <= (state_d == S_DONE);

      // Only r12 (key target) and the layout sanity result are needed later.
      if (state_q == S_IDLE && start) begin
        key_sel_q   <= r12;
        valid_cfg_q <= (r12 < r13) && (r14 <= r15);
        success_q   <= 1'b0;
      end

      // New ID is consumed during ENABLE, advanced on the way out.
      if (state_q == S_ENABLE) next_id_q <= next_id_d;

      if (state_q == S_KDF_REQ) begin
        cnt_q <= '0;
        tmo_q <= 8'h00;
      end

      if (state_q == S_KEY_WR) begin
        if (kdf_valid) begin
          cnt_q <= cnt_q + KEY_IDX_SIZE'(1);
          tmo_q <= 8'h00;
        end else begin
          tmo_q <= tmo_q + 8'h01;
        end
      end

      if (state_d == S_DONE) success_q <= ok_d;
    end
  end

  assign busy           = busy_q;
  assign check_new_spm  = chk_q;
  assign update_spm     = upd_q;
  assign enable_spm     = upd_q;
  assign next_id        = next_id_q;
  assign spm_key_select = key_sel_q;
  assign kdf_start      = kdfs_q;
  assign kdf_ready      = rdy_q;
  // Key words pass straight through in the cycle the KDF presents them.
  assign write_key      = rdy_q & kdf_valid;
  assign key_in         = kdf_data;
  assign key_idx        = cnt_q;
  assign done           = done_q;
  assign success        = success_q;

endmodule

// File: tb/tb_omsp_spm_protect_ctrl.sv
// Bench for the protect sequencer: directed scenarios plus random operations
// compared cycle by cycle against a timeline model of one protect operation.
module tb_omsp_spm_protect_ctrl;

  localparam int KEY_IDX_SIZE = 2;
  localparam int KEY_WORDS    = 4;
  localparam int KDF_TIMEOUT  = 255;
  localparam int MAXC         = 2048;

  logic                    mclk = 1'b0;
  logic                    puc_rst, start, violation_any, kdf_valid;
  logic [15:0]             r12, r13, r14, r15, kdf_data;
  logic                    busy, check_new_spm, update_spm, enable_spm;
  logic [15:0]             next_id, spm_key_select, key_in;
  logic                    kdf_start, kdf_ready, write_key, done, success;
  logic [KEY_IDX_SIZE-1:0] key_idx;

  int checks   = 0;
  int failures = 0;

  // model state carried between operations
  logic [15:0] m_id, m_sel;
  logic        m_succ;

  always #5 mclk = ~mclk;

  omsp_spm_protect_ctrl #(
    .KEY_IDX_SIZE(KEY_IDX_SIZE), .KEY_WORDS(KEY_WORDS), .KDF_TIMEOUT(KDF_TIMEOUT)
  ) dut (
    .mclk(mclk), .puc_rst(puc_rst), .start(start),
    .r12(r12), .r13(r13), .r14(r14), .r15(r15),
    .violation_any(violation_any), .kdf_valid(kdf_valid), .kdf_data(kdf_data),
    .busy(busy), .check_new_spm(check_new_spm), .update_spm(update_spm),
    .enable_spm(enable_spm), .next_id(next_id), .spm_key_select(spm_key_select),
    .kdf_start(kdf_start), .kdf_ready(kdf_ready), .write_key(write_key),
    .key_in(key_in), .key_idx(key_idx), .done(done), .success(success)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] strobes();
    return {busy, check_new_spm, update_spm, enable_spm, kdf_start,
            kdf_ready, write_key, done, success};
  endfunction

  // One protect operation. Cycle 0 carries the start pulse; the spec timeline
  // puts CHECK at 1, ENABLE at 2, KDF request at 3 and key streaming from 4.
  // mode 0: random kdf_valid density, 1: valid every cycle with A0.. data,
  // 2: two words then silence. rst_at >= 0 fires puc_rst in that cycle.
  task automatic run_op(input logic [15:0] a, b, c, d, input bit viol,
                        input int mode, input int rst_at);
    bit          v[MAXC];
    logic [15:0] dat[MAXC];
    bit          fail_chk, ok, e_chk, e_upd, e_kdfs, e_rdy, e_wk, e_done, e_busy, e_succ;
    int          done_t, words, gap, p, last_t, cap, idx;
    logic [15:0] id_after, e_id;

    p = $urandom_range(25, 100);
    for (int t = 0; t < MAXC; t++) begin
      dat[t] = 16'($urandom);
      case (mode)
        1:       v[t] = (t >= 4) ? 1'b1 : 1'($urandom_range(0, 1));
        2:       v[t] = (t >= 6) ? 1'b0 : ((t >= 4) ? 1'b1 : 1'($urandom_range(0, 1)));
        default: v[t] = ($urandom_range(0, 99) < p);
      endcase
      if (mode == 1 && t >= 4 && t < 4 + KEY_WORDS) dat[t] = 16'hA0 + 16'(t - 4);
    end

    // outcome of the operation from the protect rules
    fail_chk = viol || !((a < b) && (c <= d));
    ok = 1'b0;
    if (fail_chk) done_t = 2;
    else begin
      words = 0; gap = 0; done_t = -1;
      for (int t = 4; t < MAXC - 4 && done_t < 0; t++) begin
        if (v[t]) begin
          words++; gap = 0;
          if (words == KEY_WORDS) begin done_t = t + 1; ok = 1'b1; end
        end else begin
          gap++;
          if (gap == KDF_TIMEOUT) done_t = t + 1;
        end
      end
    end
    id_after = fail_chk ? m_id : ((m_id == 16'hFFFF) ? 16'h0001 : m_id + 16'd1);
    last_t = (rst_at >= 0) ? rst_at + 1 : done_t + 2;
    cap    = (rst_at >= 0) ? rst_at : done_t;
    idx    = 0;

    for (int t = 0; t <= last_t; t++) begin
      @(posedge mclk); #1;
      puc_rst       = (t == rst_at);
      start         = (t == 0) || (t <= cap && $urandom_range(0, 3) == 0);
      r12           = (t == 0) ? a : 16'($urandom);
      r13           = (t == 0) ? b : 16'($urandom);
      r14           = (t == 0) ? c : 16'($urandom);
      r15           = (t == 0) ? d : 16'($urandom);
      violation_any = (t == 1) ? viol : 1'($urandom_range(0, 1));
      kdf_valid     = v[t];
      kdf_data      = dat[t];
      @(negedge mclk);
      if (rst_at >= 0 && t == rst_at + 1) begin
        chk("reset_strobes", 32'(strobes()), 32'd0);
        chk("reset_next_id", 32'(next_id), 32'h0001);
        chk("reset_key_select", 32'(spm_key_select), 32'd0);
        chk("reset_key_idx", 32'(key_idx), 32'd0);
      end else begin
        e_chk  = (t == 1);
        e_upd  = !fail_chk && t == 2;
        e_kdfs = !fail_chk && t == 3;
        e_rdy  = !fail_chk && t >= 4 && t < done_t;
        e_wk   = e_rdy && v[t];
        e_done = (t == done_t);
        e_busy = (t >= 1 && t <= done_t);
        e_succ = (t == 0) ? m_succ : ((t < done_t) ? 1'b0 : ok);
        e_id   = (t <= 2) ? m_id : id_after;
        chk($sformatf("strobes t=%0d", t), 32'(strobes()),
            32'({e_busy, e_chk, e_upd, e_upd, e_kdfs, e_rdy, e_wk, e_done, e_succ}));
        chk($sformatf("next_id t=%0d", t), 32'(next_id), 32'(e_id));
        chk($sformatf("key_select t=%0d", t), 32'(spm_key_select),
            32'((t == 0) ? m_sel : a));
        if (e_wk) begin
          chk($sformatf("key_idx t=%0d", t), 32'(key_idx), 32'(idx));
          chk($sformatf("key_in t=%0d", t), 32'(key_in), 32'(dat[t]));
          idx++;
        end
      end
    end
    puc_rst = 1'b0;
    start   = 1'b0;
    if (rst_at >= 0) begin
      m_id = 16'h0001; m_succ = 1'b0; m_sel = 16'h0000;
    end else begin
      m_id = id_after; m_succ = ok; m_sel = a;
    end
  endtask

  initial begin
    logic [15:0] a, b, c, d;
    bit          viol;
    puc_rst = 1'b1; start = 1'b0; violation_any = 1'b0; kdf_valid = 1'b0;
    kdf_data = 16'h0; r12 = 16'h0; r13 = 16'h0; r14 = 16'h0; r15 = 16'h0;
    m_id = 16'h0001; m_sel = 16'h0000; m_succ = 1'b0;
    repeat (2) @(posedge mclk);
    @(negedge mclk);
    chk("por_strobes", 32'(strobes()), 32'd0);
    chk("por_next_id", 32'(next_id), 32'h0001);
    chk("por_key_select", 32'(spm_key_select), 32'd0);
    chk("por_key_idx", 32'(key_idx), 32'd0);
    puc_rst = 1'b0;

    // good layout, key streamed back to back
    run_op(16'h8000, 16'h8100, 16'h0200, 16'h0280, 1'b0, 1, -1);
    // overlap violation reported during the check
    run_op(16'h8000, 16'h8100, 16'h0200, 16'h0280, 1'b1, 1, -1);
    // inverted public section
    run_op(16'h8100, 16'h8000, 16'h0200, 16'h0280, 1'b0, 1, -1);
    // KDF goes silent after two words: abort after KDF_TIMEOUT idle cycles
    run_op(16'h9000, 16'h9100, 16'h0300, 16'h0300, 1'b0, 2, -1);
    // ID wrap from 0xFFFF skips the reserved 0
    @(negedge mclk);
    force dut.next_id_q = 16'hFFFF;
    @(negedge mclk);
    release dut.next_id_q;
    m_id = 16'hFFFF;
    run_op(16'h8000, 16'h8100, 16'h0200, 16'h0280, 1'b0, 1, -1);
    // reset in the middle of key streaming
    run_op(16'hA000, 16'hA100, 16'h0400, 16'h0480, 1'b0, 1, 5);
    run_op(16'h8000, 16'h8100, 16'h0200, 16'h0280, 1'b0, 1, -1);

    for (int n = 0; n < 30; n++) begin
      a = 16'($urandom_range(0, 16'hEFFF));
      c = 16'($urandom_range(0, 16'hEFFF));
      b = ($urandom_range(0, 9) < 8) ? a + 16'($urandom_range(1, 4096)) : a - 16'($urandom_range(0, 8));
      d = ($urandom_range(0, 9) < 8) ? c + 16'($urandom_range(0, 4096)) : c - 16'($urandom_range(1, 8));
      viol = ($urandom_range(0, 4) == 0);
      run_op(a, b, c, d, viol, 0, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
